// File: rtl/hack_mem_pkg.sv
// Shared address map, region type and event layout for the Hack memory block.
package hack_mem_pkg;

  localparam logic [14:0] RAM_BASE    = 15'h0000;
  localparam logic [14:0] SCREEN_BASE = 15'h4000;
  localparam logic [14:0] KBD_ADDR    = 15'h6000;

  localparam int RAM_WORDS    = 16384;
  localparam int SCREEN_WORDS = 8192;

  typedef enum logic [1:0] {
    RAM,
    SCREEN,
    KBD,
    UNMAPPED
  } region_e;

  typedef struct packed {
    logic [12:0] addr;
    logic [15:0] data;
  } scr_event_t;

  function automatic region_e decode_region(input logic [14:0] addr);
    if (addr < SCREEN_BASE)   return RAM;
    else if (addr < KBD_ADDR) return SCREEN;
    else if (addr == KBD_ADDR) return KBD;
    else                      return UNMAPPED;
  endfunction

  function automatic logic [13:0] ram_index(input logic [14:0] addr);
    return 14'(addr - RAM_BASE);
  endfunction

  function automatic logic [12:0] screen_offset(input logic [14:0] addr);
    return 13'(addr - SCREEN_BASE);
  endfunction

endpackage

// File: rtl/event_fifo.sv
// Screen-event FIFO: power-of-two depth, pointers carry one extra wrap bit.
// A push into a full FIFO is kept only if the head is popped on the same edge.
module event_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 29
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_head,
  output logic             o_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             r_overflow;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push_ok;

  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop     = !w_empty && i_pop_ready;
  assign w_push_ok = i_push && (!w_full || w_pop);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)     r_rd_ptr <= r_rd_ptr + PTR_ONE;
      if (i_push && !w_push_ok) r_overflow <= 1'b1;
    end
  end

  // NOTE: storage is not reset; emptiness is tracked by the pointers alone,
  // and leaving the array out of reset lets it map onto RAM primitives.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
  end

  assign o_valid    = !w_empty;
  assign o_head     = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
  assign o_overflow = r_overflow;

endmodule

// File: rtl/hack_memory.sv
// Hack computer data memory: RAM, memory-mapped SCREEN and KBD, with every
// SCREEN write also queued as an event for an external display consumer.
module hack_memory
  import hack_mem_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [14:0] addressM,
  input  logic [15:0] outM,
  input  logic        writeM,
  output logic [15:0] inM,
  input  logic [15:0] kbd_code,
  input  logic        kbd_valid,
  output logic        kbd_ready,
  output logic [12:0] scr_addr,
  output logic [15:0] scr_data,
  output logic        scr_valid,
  input  logic        scr_ready,
  output logic        scr_overflow
);

  logic [15:0] r_ram    [RAM_WORDS];
  logic [15:0] r_screen [SCREEN_WORDS];
  logic [15:0] r_kbd;

  region_e     w_region;
  logic [13:0] w_ram_idx;
  logic [12:0] w_scr_off;
  logic        w_ram_we;
  logic        w_scr_we;
  scr_event_t  w_event;
  scr_event_t  w_head;

  assign w_region  = decode_region(addressM);
  assign w_ram_idx = ram_index(addressM);
  assign w_scr_off = screen_offset(addressM);
  assign w_ram_we  = writeM && (w_region == RAM);
  assign w_scr_we  = writeM && (w_region == SCREEN);

  always_ff @(posedge clk) begin
    if (w_ram_we) r_ram[w_ram_idx]    <= outM;
    if (w_scr_we) r_screen[w_scr_off] <= outM;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)          r_kbd <= '0;
    else if (kbd_valid) r_kbd <= kbd_code;
  end

  assign kbd_ready = !reset;

  // NOTE: a default before the case keeps this purely combinational even if
  // a region is added later without a matching branch.
  always_comb begin
    inM = '0;
    unique case (w_region)
      RAM:     inM = r_ram[w_ram_idx];
      SCREEN:  inM = r_screen[w_scr_off];
      KBD:     inM = r_kbd;
      default: inM = '0;
    endcase
  end

  assign w_event.addr = w_scr_off;
  assign w_event.data = outM;

  event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(scr_event_t))
  ) u_event_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_push      (w_scr_we),
    .i_push_data (w_event),
    .i_pop_ready (scr_ready),
    .o_valid     (scr_valid),
    .o_head      (w_head),
    .o_overflow  (scr_overflow)
  );

  assign scr_addr = w_head.addr;
  assign scr_data = w_head.data;

endmodule

// File: tb/tb_hack_memory.sv
// Directed bench for hack_memory: a memory/queue model checked every cycle,
// plus hand-computed expectations for the key scenarios.
module tb_hack_memory;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [14:0] addressM = '0;
  logic [15:0] outM = '0;
  logic        writeM = 1'b0;
  logic [15:0] inM;
  logic [15:0] kbd_code = '0;
  logic        kbd_valid = 1'b0;
  logic        kbd_ready;
  logic [12:0] scr_addr;
  logic [15:0] scr_data;
  logic        scr_valid;
  logic        scr_ready = 1'b0;
  logic        scr_overflow;

  hack_memory #(.FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .addressM     (addressM),
    .outM         (outM),
    .writeM       (writeM),
    .inM          (inM),
    .kbd_code     (kbd_code),
    .kbd_valid    (kbd_valid),
    .kbd_ready    (kbd_ready),
    .scr_addr     (scr_addr),
    .scr_data     (scr_data),
    .scr_valid    (scr_valid),
    .scr_ready    (scr_ready),
    .scr_overflow (scr_overflow)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Model: sparse memories, keyboard word, event queue, sticky overflow.
  logic [15:0] m_ram [int];
  logic [15:0] m_scr [int];
  logic [15:0] m_kbd = '0;
  logic [28:0] m_q [$];
  logic        m_ovf = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic int region_of(input int a);
    if (a < 'h4000)       return 0;
    else if (a < 'h6000)  return 1;
    else if (a == 'h6000) return 2;
    else                  return 3;
  endfunction

  task automatic model_reset();
    m_kbd = '0;
    m_q.delete();
    m_ovf = 1'b0;
  endtask

  task automatic model_edge();
    int  r;
    bit  pop;
    r   = region_of(int'(addressM));
    pop = (m_q.size() > 0) && scr_ready;
    if (reset) begin
      model_reset();
    end else begin
      if (kbd_valid) m_kbd = kbd_code;
      if (writeM && r == 0) m_ram[int'(addressM)] = outM;
      if (pop) void'(m_q.pop_front());
      if (writeM && r == 1) begin
        m_scr[int'(addressM) - 'h4000] = outM;
        if (m_q.size() < DEPTH) m_q.push_back({13'(int'(addressM) - 'h4000), outM});
        else m_ovf = 1'b1;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input bit we, input int a, input int d);
    writeM   = we;
    addressM = 15'(a);
    outM     = 16'(d);
  endtask

  int          c_reg;
  int          c_a;
  logic [28:0] c_head;

  always @(negedge clk) begin
    c_a   = int'(addressM);
    c_reg = region_of(c_a);
    case (c_reg)
      0: if (m_ram.exists(c_a)) check("model_inM_ram", 32'(inM), 32'(m_ram[c_a]));
      1: if (m_scr.exists(c_a - 'h4000)) check("model_inM_scr", 32'(inM), 32'(m_scr[c_a - 'h4000]));
      2: check("model_inM_kbd", 32'(inM), 32'(m_kbd));
      default: check("model_inM_unmapped", 32'(inM), 32'h0);
    endcase
    c_head = (m_q.size() > 0) ? m_q[0] : 29'h0;
    check("model_scr_valid", 32'(scr_valid), 32'(m_q.size() > 0));
    check("model_scr_addr", 32'(scr_addr), 32'(c_head[28:16]));
    check("model_scr_data", 32'(scr_data), 32'(c_head[15:0]));
    check("model_scr_overflow", 32'(scr_overflow), 32'(m_ovf));
    check("model_kbd_ready", 32'(kbd_ready), 32'(!reset));
  end

  initial begin
    repeat (3) step();
    check("rst_kbd_ready", 32'(kbd_ready), 32'h0);
    check("rst_scr_valid", 32'(scr_valid), 32'h0);
    check("rst_scr_addr", 32'(scr_addr), 32'h0);
    check("rst_scr_data", 32'(scr_data), 32'h0);
    check("rst_overflow", 32'(scr_overflow), 32'h0);
    reset = 1'b0;

    // RAM write: old data during the write cycle, new data afterwards
    drive(1, 'h0010, 'h5555); step();
    drive(1, 'h0010, 'h1234); #1;
    check("ram_wr_cycle_old", 32'(inM), 32'h5555);
    step();
    drive(0, 'h0010, 0); #1;
    check("ram_next_new", 32'(inM), 32'h1234);
    check("ram_no_event", 32'(scr_valid), 32'h0);

    // Keyboard load, then ignored CPU write to KBD
    kbd_code = 16'h0041; kbd_valid = 1'b1; step();
    kbd_valid = 1'b0; kbd_code = '0;
    drive(0, 'h6000, 0); #1;
    check("kbd_read", 32'(inM), 32'h0041);
    check("kbd_ready_run", 32'(kbd_ready), 32'h1);
    drive(1, 'h6000, 'hFFFF); step();
    drive(0, 'h6000, 0); #1;
    check("kbd_write_ignored", 32'(inM), 32'h0041);

    // Single screen event with consumer ready
    scr_ready = 1'b1;
    drive(1, 'h4005, 'hAAAA); step();
    drive(0, 'h0010, 0); #1;
    check("scr1_valid", 32'(scr_valid), 32'h1);
    check("scr1_addr", 32'(scr_addr), 32'h0005);
    check("scr1_data", 32'(scr_data), 32'hAAAA);
    step();
    check("scr1_drained", 32'(scr_valid), 32'h0);

    // Full FIFO with simultaneous push and pop
    scr_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1, 'h4200 + i, 'hC000 + i); step();
    end
    drive(0, 'h0010, 0); #1;
    check("full_head_addr", 32'(scr_addr), 32'h0200);
    scr_ready = 1'b1;
    drive(1, 'h4204, 'hC004); step();
    scr_ready = 1'b0;
    drive(0, 'h7000, 0); #1;
    check("pushpop_no_overflow", 32'(scr_overflow), 32'h0);
    check("unmapped_zero", 32'(inM), 32'h0);
    scr_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check("pushpop_drain_addr", 32'(scr_addr), 32'h0200 + 32'(i));
      check("pushpop_drain_data", 32'(scr_data), 32'hC000 + 32'(i));
      step();
    end
    check("pushpop_empty", 32'(scr_valid), 32'h0);

    // Overflow: five writes while the consumer stalls
    scr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1, 'h4100 + i, 'hB000 + i); step();
    end
    drive(0, 'h0010, 0); #1;
    check("ovf_set", 32'(scr_overflow), 32'h1);
    check("ovf_stall_stable_addr", 32'(scr_addr), 32'h0100);
    step();
    check("ovf_stall_stable_data", 32'(scr_data), 32'hB000);
    scr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("ovf_drain_addr", 32'(scr_addr), 32'h0100 + 32'(i));
      check("ovf_drain_data", 32'(scr_data), 32'hB000 + 32'(i));
      step();
    end
    check("ovf_drained", 32'(scr_valid), 32'h0);
    check("ovf_sticky", 32'(scr_overflow), 32'h1);

    // Reset mid-stream with three pending events
    scr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1, 'h4300 + i, 'hD000 + i); step();
    end
    drive(0, 'h6000, 0); #1;
    check("pre_rst_pending", 32'(scr_valid), 32'h1);
    reset = 1'b1;
    model_reset();
    #1;
    check("async_rst_valid", 32'(scr_valid), 32'h0);
    check("async_rst_overflow", 32'(scr_overflow), 32'h0);
    check("async_rst_kbd", 32'(inM), 32'h0);
    check("async_rst_scr_addr", 32'(scr_addr), 32'h0);
    check("async_rst_kbd_ready", 32'(kbd_ready), 32'h0);
    step(); step();
    reset = 1'b0;
    drive(0, 'h0010, 0); #1;
    check("ram_retained", 32'(inM), 32'h1234);
    drive(0, 'h4005, 0); #1;
    check("screen_retained", 32'(inM), 32'hAAAA);
    check("post_rst_empty", 32'(scr_valid), 32'h0);
    repeat (2) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/hack_memory.md
HACK_MEMORY -- requirements
Module: hack_memory

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning screen-event FIFO entries (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on posedge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port addressM  input  15  word address from CPU.
REQ-005 SHALL have port outM  input  16  write data from CPU.
REQ-006 SHALL have port writeM  input  1  write strobe from CPU.
REQ-007 SHALL have port inM  output  16  read data to CPU.
REQ-008 SHALL have port kbd_code  input  16  key code from keyboard source; 0 = no key.
REQ-009 SHALL have port kbd_valid  input  1  kbd_code is valid this cycle.
REQ-010 SHALL have port kbd_ready  output  1  block accepts kbd_code.
REQ-011 SHALL have port scr_addr  output  13  screen word offset of the oldest pending event.
REQ-012 SHALL have port scr_data  output  16  pixel word of the oldest pending event.
REQ-013 SHALL have port scr_valid  output  1  an event is pending.
REQ-014 SHALL have port scr_ready  input  1  display consumer accepts the event.
REQ-015 SHALL have port scr_overflow  output  1  sticky flag: a screen event was dropped.

Function
REQ-016 SHALL decode the address map: 0x0000-0x3FFF RAM (16K words), 0x4000-0x5FFF SCREEN (8K words), 0x6000 KBD, 0x6001-0x7FFF UNMAPPED.
REQ-017 SHALL drive inM combinationally from addressM in the same cycle: RAM/SCREEN word, the KBD register, or 0 for UNMAPPED.
REQ-018 SHALL write outM to RAM or SCREEN at posedge when writeM=1; writes to KBD or UNMAPPED SHALL be ignored.
REQ-019 SHALL show old data on inM during a write cycle and new data from the next cycle onward.
REQ-020 SHALL hold kbd_ready=1 outside reset and load kbd_code into the KBD register at posedge when kbd_valid=1; otherwise the register holds its value.
REQ-021 SHALL push {addressM-0x4000, outM} into the event FIFO on every SCREEN write, with scr_valid asserted the cycle after a push into an empty FIFO.
REQ-022 SHALL pop the head entry at posedge when scr_valid=1 and scr_ready=1; scr_addr/scr_data SHALL stay stable while scr_valid=1 and scr_ready=0.
REQ-023 SHALL accept a push when full only if a pop occurs in the same cycle; otherwise it SHALL drop the event (SCREEN RAM still written) and set scr_overflow.
REQ-024 SHALL allow a simultaneous push and pop on a non-empty FIFO with occupancy unchanged; on an empty FIFO the push takes effect and no pop occurs.
REQ-025 SHALL wrap FIFO read/write pointers modulo FIFO_DEPTH, using an extra pointer bit to distinguish full from empty.
REQ-026 SHALL keep scr_overflow set until reset.

Reset
REQ-027 SHALL, on reset, asynchronously clear the KBD register, FIFO pointers and scr_overflow, and force kbd_ready=0, scr_valid=0, scr_addr=0 and scr_data=0.
REQ-028 SHALL NOT reset RAM or SCREEN contents; reset asserted mid-stream SHALL discard all pending events.

Structure
REQ-029 SHALL take RAM_BASE, SCREEN_BASE=0x4000, KBD_ADDR=0x6000 and a region enum {RAM, SCREEN, KBD, UNMAPPED} from shared package hack_mem_pkg.
REQ-030 SHALL implement the event FIFO as sub-module event_fifo, parameterised by depth and width.

Verification
REQ-031 SHALL cover: write 0x1234 to 0x0010 -> inM=old value in the write cycle, 0x1234 on the next read of 0x0010; no screen event.
REQ-032 SHALL cover: kbd_code=0x0041 with kbd_valid=1 for one cycle, then reading 0x6000 -> inM=0x0041; writing 0xFFFF to 0x6000 -> inM still 0x0041.
REQ-033 SHALL cover: write 0xAAAA to 0x4005 with scr_ready=1 -> scr_valid=1 next cycle with scr_addr=0x0005 and scr_data=0xAAAA, then scr_valid=0.
REQ-034 SHALL cover: scr_ready=0 during 5 screen writes -> 4 entries held, scr_overflow=1, then draining returns the first 4 events in order.
REQ-035 SHALL cover: full FIFO with push and pop in the same cycle -> no overflow and occupancy stays 4; reads of 0x7000 -> inM=0.
REQ-036 SHALL cover: reset asserted with 3 pending events -> scr_valid=0 and scr_overflow=0 immediately, KBD reads 0, RAM data retained.
